// File: rtl/fpu_arbiter_if.sv
// Requester and FPU-side signal bundle for fpu_arbiter.
// The slave modport is the arbiter's view; master is the requester/FPU environment.
interface fpu_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] op_a;
  logic [32*N_REQ-1:0] op_b;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rsp_valid;
  logic [31:0]         rsp_data;
  logic [3:0]          rsp_status;
  logic                busy;
  logic                fpu_rst_n;
  logic [31:0]         fpu_op_a;
  logic [31:0]         fpu_op_b;
  logic [31:0]         fpu_data;
  logic [3:0]          fpu_status;

  modport slave (
    input  req, op_a, op_b, fpu_data, fpu_status,
    output gnt, rsp_valid, rsp_data, rsp_status, busy, fpu_rst_n, fpu_op_a, fpu_op_b
  );

  modport master (
    output req, op_a, op_b, fpu_data, fpu_status,
    input  gnt, rsp_valid, rsp_data, rsp_status, busy, fpu_rst_n, fpu_op_a, fpu_op_b
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin sharing of one FPU between N_REQ requesters; the FPU is held in
// reset while idle and released for a fixed window per job.
module fpu_arbiter #(
  parameter int N_REQ       = 4,
  parameter int FPU_LATENCY = 40
) (
  input  logic           clock_100Khz,
  input  logic           reset,
  fpu_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
  localparam logic [3:0] STATUS_EXACT = 4'd2;

  typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic [3:0]         rsp_status_q, rsp_status_d;
  logic               busy_q, busy_d;
  logic               fpu_rst_n_q, fpu_rst_n_d;
  logic [31:0]        fpu_op_a_q, fpu_op_a_d;
  logic [31:0]        fpu_op_b_q, fpu_op_b_d;

  logic [31:0]        op_a_arr [N_REQ];
  logic [31:0]        op_b_arr [N_REQ];
  logic [PTR_W-1:0]   win;
  logic               win_found;
  int                 idx;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign op_a_arr[gi] = bus.op_a[32*gi +: 32];
    assign op_b_arr[gi] = bus.op_b[32*gi +: 32];
  end

  // First set request scanning upward from the round-robin pointer, wrapping.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_found && bus.req[PTR_W'(idx)]) begin
        win       = PTR_W'(idx);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    gnt_d        = '0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    busy_d       = busy_q;
    fpu_rst_n_d  = fpu_rst_n_q;
    fpu_op_a_d   = fpu_op_a_q;
    fpu_op_b_d   = fpu_op_b_q;
    unique case (state_q)
      IDLE: begin
        fpu_rst_n_d = 1'b0;
        if (win_found) begin
          gnt_d      = N_REQ'(1) << win;
          fpu_op_a_d = op_a_arr[win];
          fpu_op_b_d = op_b_arr[win];
          owner_d    = win;
          ptr_d      = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
          busy_d     = 1'b1;
          state_d    = FLUSH;
        end
      end
      FLUSH: begin
        cnt_d       = CNT_W'(FPU_LATENCY - 1);
        fpu_rst_n_d = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        rsp_data_d   = bus.fpu_data;
        rsp_status_d = bus.fpu_status;
        rsp_valid_d  = N_REQ'(1) << owner_q;
        fpu_rst_n_d  = 1'b0;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Asynchronous reset also drops fpu_rst_n at once, killing any job in flight.
  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      owner_q      <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= STATUS_EXACT;
      busy_q       <= 1'b0;
      fpu_rst_n_q  <= 1'b0;
      fpu_op_a_q   <= '0;
      fpu_op_b_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      busy_q       <= busy_d;
      fpu_rst_n_q  <= fpu_rst_n_d;
      fpu_op_a_q   <= fpu_op_a_d;
      fpu_op_b_q   <= fpu_op_b_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.busy       = busy_q;
  assign bus.fpu_rst_n  = fpu_rst_n_q;
  assign bus.fpu_op_a   = fpu_op_a_q;
  assign bus.fpu_op_b   = fpu_op_b_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter with an adder stub standing in for the FPU; expected
// responses are queued when requests are driven and popped on rsp_valid.
module tb_fpu_arbiter;
  localparam int N   = 4;
  localparam int LAT = 4;

  logic clk;
  logic rst_n;

  fpu_arbiter_if #(.N_REQ(N)) bus();

  fpu_arbiter #(.N_REQ(N), .FPU_LATENCY(LAT)) dut (
    .clock_100Khz(clk),
    .reset       (rst_n),
    .bus         (bus)
  );

  typedef struct {
    int          owner;
    logic [31:0] data;
    logic [3:0]  status;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub FPU: registered sum while released, cleared whenever held in reset.
  always_ff @(posedge clk or negedge bus.fpu_rst_n) begin
    if (!bus.fpu_rst_n) begin
      bus.fpu_data   <= '0;
      bus.fpu_status <= 4'd2;
    end else begin
      bus.fpu_data   <= bus.fpu_op_a + bus.fpu_op_b;
      bus.fpu_status <= 4'd2;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.op_a[32*i +: 32] = a;
    bus.op_b[32*i +: 32] = b;
  endtask

  task automatic wait_rsp(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget) begin
      step();
      n++;
      if ((|bus.rsp_valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (2) step();
    n_checks++; if (bus.gnt !== 4'b0) $display("FAIL reset_gnt: got %b want 0000", bus.gnt); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 4'b0) $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.fpu_rst_n !== 1'b0) $display("FAIL reset_fpu_rst_n: got %b want 0", bus.fpu_rst_n); else n_pass++;
    n_checks++; if (bus.rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); else n_pass++;
    n_checks++; if (bus.rsp_status !== 4'd2) $display("FAIL reset_rsp_status: got %0d want 2", bus.rsp_status); else n_pass++;
    n_checks++; if ({bus.fpu_op_a, bus.fpu_op_b} !== 64'h0) $display("FAIL reset_ops: got %h want 0", {bus.fpu_op_a, bus.fpu_op_b}); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    exp_t e;
    int   hi;
    set_op(1, 32'h10, 32'h05);
    bus.req = 4'b0010;
    sb_q.push_back('{1, 32'h15, 4'd2});
    step();
    $display("single: gnt=%b fpu_op_a=%h fpu_op_b=%h", bus.gnt, bus.fpu_op_a, bus.fpu_op_b);
    n_checks++; if (bus.gnt !== 4'b0010) $display("FAIL single_gnt: got %b want 0010", bus.gnt); else n_pass++;
    n_checks++; if (bus.fpu_rst_n !== 1'b0) $display("FAIL single_flush_rst: got %b want 0", bus.fpu_rst_n); else n_pass++;
    n_checks++; if (bus.fpu_op_a !== 32'h10 || bus.fpu_op_b !== 32'h05) $display("FAIL single_ops: got %h/%h want 10/05", bus.fpu_op_a, bus.fpu_op_b); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy); else n_pass++;
    bus.req = '0;
    hi = 0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (bus.fpu_rst_n === 1'b1) hi++;
    end
    n_checks++; if (hi != 5) $display("FAIL single_run_window: got %0d want 5", hi); else n_pass++;
    step();
    e = sb_q.pop_front();
    $display("single: rsp_valid=%b rsp_data=%h rsp_status=%0d", bus.rsp_valid, bus.rsp_data, bus.rsp_status);
    n_checks++; if (bus.rsp_valid !== 4'(1 << e.owner)) $display("FAIL single_rsp_valid: got %b want %b", bus.rsp_valid, 4'(1 << e.owner)); else n_pass++;
    n_checks++; if (bus.rsp_data !== e.data) $display("FAIL single_rsp_data: got %h want %h", bus.rsp_data, e.data); else n_pass++;
    n_checks++; if (bus.rsp_status !== e.status) $display("FAIL single_rsp_status: got %0d want %0d", bus.rsp_status, e.status); else n_pass++;
    n_checks++; if (bus.fpu_rst_n !== 1'b0 || bus.busy !== 1'b0) $display("FAIL single_done_idle: got rst_n=%b busy=%b want 0/0", bus.fpu_rst_n, bus.busy); else n_pass++;
    last_data = e.data;
    step();
    n_checks++; if (bus.rsp_valid !== 4'b0) $display("FAIL single_pulse_width: got %b want 0000", bus.rsp_valid); else n_pass++;
  endtask

  task automatic test_pointer_skip();
    exp_t e;
    int   n;
    bit   ok;
    set_op(0, 32'h200, 32'h22);
    set_op(1, 32'h300, 32'h33);
    bus.req = 4'b0011;
    sb_q.push_back('{0, 32'h222, 4'd2});
    sb_q.push_back('{1, 32'h333, 4'd2});
    step();
    $display("skip: gnt=%b", bus.gnt);
    n_checks++; if (bus.gnt !== 4'b0001) $display("FAIL skip_gnt0: got %b want 0001", bus.gnt); else n_pass++;
    for (int j = 0; j < 2; j++) begin
      wait_rsp(20, n, ok);
      n_checks++; if (!ok || n != LAT + 2) $display("FAIL skip_rsp_latency: got %0d want %0d", ok ? n : -1, LAT + 2); else n_pass++;
      e = sb_q.pop_front();
      $display("skip: rsp_valid=%b rsp_data=%h", bus.rsp_valid, bus.rsp_data);
      n_checks++; if (bus.rsp_valid !== 4'(1 << e.owner) || bus.rsp_data !== e.data) $display("FAIL skip_rsp: got %b/%h want %b/%h", bus.rsp_valid, bus.rsp_data, 4'(1 << e.owner), e.data); else n_pass++;
      last_data = e.data;
      if (j == 0) begin
        step();
        n_checks++; if (bus.gnt !== 4'b0010) $display("FAIL skip_ptr_next: got %b want 0010", bus.gnt); else n_pass++;
        bus.req = '0;
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   order[5];
    int   g, r, cyc, last;
    bit   overlap;
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < N; i++) set_op(i, 32'h1000 * (i + 1), 32'(i + 1));
    for (int k = 0; k < 5; k++) sb_q.push_back('{order[k], 32'h1000 * (order[k] + 1) + 32'(order[k] + 1), 4'd2});
    bus.req = 4'b1111;
    g = 0; r = 0; cyc = 0; last = 0; overlap = 1'b0;
    while (cyc < 80 && r < 5) begin
      step();
      cyc++;
      if (((bus.gnt & bus.rsp_valid) !== 4'b0)) overlap = 1'b1;
      if ((|bus.gnt) === 1'b1) begin
        $display("rr: cycle %0d gnt=%b", cyc, bus.gnt);
        if (g < 5) begin
          n_checks++; if (bus.gnt !== 4'(1 << order[g])) $display("FAIL rr_order: got %b want %b", bus.gnt, 4'(1 << order[g])); else n_pass++;
          if (g > 0) begin
            n_checks++; if (cyc - last != LAT + 3) $display("FAIL rr_spacing: got %0d want %0d", cyc - last, LAT + 3); else n_pass++;
          end
        end else begin
          n_checks++; $display("FAIL rr_extra_gnt: got %b want 0000", bus.gnt);
        end
        last = cyc;
        g++;
        if (g == 5) bus.req = '0;
      end
      if ((|bus.rsp_valid) === 1'b1) begin
        $display("rr: cycle %0d rsp_valid=%b rsp_data=%h", cyc, bus.rsp_valid, bus.rsp_data);
        if (sb_q.size() == 0) begin
          n_checks++; $display("FAIL rr_unexpected_rsp: got %b want none", bus.rsp_valid);
        end else begin
          e = sb_q.pop_front();
          n_checks++; if (bus.rsp_valid !== 4'(1 << e.owner) || bus.rsp_data !== e.data) $display("FAIL rr_rsp: got %b/%h want %b/%h", bus.rsp_valid, bus.rsp_data, 4'(1 << e.owner), e.data); else n_pass++;
          last_data = e.data;
        end
        r++;
      end
    end
    bus.req = '0;
    n_checks++; if (r != 5) $display("FAIL rr_done: got %0d responses want 5", r); else n_pass++;
    n_checks++; if (overlap) $display("FAIL rr_gnt_rsp_overlap: got 1 want 0"); else n_pass++;
  endtask

  task automatic test_late_request();
    exp_t e;
    int   n;
    bit   ok, bad_gnt, bad_op;
    set_op(0, 32'h30, 32'h3);
    bus.req = 4'b0001;
    sb_q.push_back('{0, 32'h33, 4'd2});
    step();
    n_checks++; if (bus.gnt !== 4'b0001) $display("FAIL late_gnt0: got %b want 0001", bus.gnt); else n_pass++;
    bus.req = '0;
    step();
    step();
    set_op(3, 32'h7, 32'h8);
    bus.req = 4'b1000;
    sb_q.push_back('{3, 32'hF, 4'd2});
    bad_gnt = 1'b0; bad_op = 1'b0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ((|bus.rsp_valid) === 1'b1) begin ok = 1'b1; break; end
      if (bus.gnt !== 4'b0) bad_gnt = 1'b1;
      if (bus.fpu_op_a !== 32'h30) bad_op = 1'b1;
    end
    n_checks++; if (!ok) $display("FAIL late_rsp0_timeout: got none want rsp_valid"); else n_pass++;
    n_checks++; if (bad_gnt || bus.gnt !== 4'b0) $display("FAIL late_early_gnt: got %b want no grant before response", bus.gnt); else n_pass++;
    n_checks++; if (bad_op) $display("FAIL late_op_changed: got changed want %h held", 32'h30); else n_pass++;
    e = sb_q.pop_front();
    $display("late: rsp_valid=%b rsp_data=%h", bus.rsp_valid, bus.rsp_data);
    n_checks++; if (bus.rsp_valid !== 4'(1 << e.owner) || bus.rsp_data !== e.data) $display("FAIL late_rsp0: got %b/%h want %b/%h", bus.rsp_valid, bus.rsp_data, 4'(1 << e.owner), e.data); else n_pass++;
    step();
    n_checks++; if (bus.gnt !== 4'b1000) $display("FAIL late_gnt3: got %b want 1000", bus.gnt); else n_pass++;
    bus.req = '0;
    wait_rsp(20, n, ok);
    e = sb_q.pop_front();
    $display("late: rsp_valid=%b rsp_data=%h", bus.rsp_valid, bus.rsp_data);
    n_checks++; if (!ok || bus.rsp_valid !== 4'(1 << e.owner) || bus.rsp_data !== e.data) $display("FAIL late_rsp3: got %b/%h want %b/%h", bus.rsp_valid, bus.rsp_data, 4'(1 << e.owner), e.data); else n_pass++;
    last_data = e.data;
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int   n;
    bit   ok, stray;
    set_op(1, 32'h55, 32'h11);
    bus.req = 4'b0010;
    step();
    n_checks++; if (bus.gnt !== 4'b0010) $display("FAIL rstmid_gnt: got %b want 0010", bus.gnt); else n_pass++;
    bus.req = '0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    $display("rstmid: busy=%b fpu_rst_n=%b rsp_data=%h", bus.busy, bus.fpu_rst_n, bus.rsp_data);
    n_checks++; if (bus.busy !== 1'b0 || bus.fpu_rst_n !== 1'b0) $display("FAIL rstmid_async: got busy=%b rst_n=%b want 0/0", bus.busy, bus.fpu_rst_n); else n_pass++;
    n_checks++; if (bus.rsp_data !== 32'h0 || bus.rsp_status !== 4'd2 || bus.fpu_op_a !== 32'h0) $display("FAIL rstmid_values: got %h/%0d/%h want 0/2/0", bus.rsp_data, bus.rsp_status, bus.fpu_op_a); else n_pass++;
    repeat (2) step();
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (12) begin
      step();
      if (bus.rsp_valid !== 4'b0) stray = 1'b1;
    end
    n_checks++; if (stray) $display("FAIL rstmid_stray_rsp: got pulse want none"); else n_pass++;
    set_op(2, 32'h100, 32'h23);
    bus.req = 4'b0100;
    sb_q.push_back('{2, 32'h123, 4'd2});
    step();
    n_checks++; if (bus.gnt !== 4'b0100) $display("FAIL rstmid_regnt: got %b want 0100", bus.gnt); else n_pass++;
    bus.req = '0;
    wait_rsp(20, n, ok);
    e = sb_q.pop_front();
    $display("rstmid: rsp_valid=%b rsp_data=%h", bus.rsp_valid, bus.rsp_data);
    n_checks++; if (!ok || bus.rsp_valid !== 4'(1 << e.owner) || bus.rsp_data !== e.data) $display("FAIL rstmid_rsp: got %b/%h want %b/%h", bus.rsp_valid, bus.rsp_data, 4'(1 << e.owner), e.data); else n_pass++;
    last_data = e.data;
  endtask

  task automatic test_idle_hold();
    bit bad_rst, bad_busy, bad_data;
    bad_rst = 1'b0; bad_busy = 1'b0; bad_data = 1'b0;
    bus.req = '0;
    repeat (50) begin
      step();
      if (bus.fpu_rst_n !== 1'b0) bad_rst = 1'b1;
      if (bus.busy !== 1'b0) bad_busy = 1'b1;
      if (bus.rsp_data !== last_data) bad_data = 1'b1;
    end
    $display("idle: fpu_rst_n=%b busy=%b rsp_data=%h", bus.fpu_rst_n, bus.busy, bus.rsp_data);
    n_checks++; if (bad_rst) $display("FAIL idle_fpu_rst_n: got 1 want 0"); else n_pass++;
    n_checks++; if (bad_busy) $display("FAIL idle_busy: got 1 want 0"); else n_pass++;
    n_checks++; if (bad_data) $display("FAIL idle_rsp_data: got %h want %h", bus.rsp_data, last_data); else n_pass++;
    n_checks++; if (sb_q.size() != 0) $display("FAIL scoreboard_left: got %0d want 0", sb_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_pointer_skip();
    test_round_robin();
    test_late_request();
    test_reset_mid_run();
    test_idle_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
